// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - rounding mode constants and signed range helpers for requant_pipe
package requant_pkg;

  localparam logic [1:0] MODE_FLOOR     = 2'd0;
  localparam logic [1:0] MODE_HALF_UP   = 2'd1;
  localparam logic [1:0] MODE_HALF_EVEN = 2'd2;
  localparam logic [1:0] MODE_TO_ZERO   = 2'd3;

  function automatic int sat_max(input int width);
    return (1 <<< (width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int width);
    return -(1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one channel: stage 1 truncates and decodes the rounding increment,
// stage 2 adds it and saturates to the output width
module requant_lane
  import requant_pkg::*;
#(
  parameter int NB_XI  = 17,
  parameter int NBF_XI = 10,
  parameter int NB_XO  = 9,
  parameter int NBF_XO = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [NB_XI-1:0] i_x,
  input  logic [1:0]       i_mode,
  output logic [NB_XO-1:0] o_y,
  output logic             o_sat
);

  localparam int K     = NBF_XI - NBF_XO;
  localparam int NB_Y  = NB_XI - K;
  localparam int NB_R  = NB_Y + 1;
  localparam int MAX_I = sat_max(NB_XO);
  localparam int MIN_I = sat_min(NB_XO);

  logic [NB_Y-1:0]  y_q, y_d;
  logic             inc_q, inc_d;
  logic [NB_XO-1:0] data_q, data_d;
  logic             sat_q, sat_d;

  logic                   guard, sticky, inc_mode;
  logic signed [NB_R-1:0] y_round;
  int                     y_round_i;

  always_comb begin
    guard  = 1'b0;
    sticky = 1'b0;
    // Both stay 0 when K=0, so every mode degenerates to a plain copy.
    for (int b = 0; b < NB_XI; b++) begin
      if (b == K - 1) guard = i_x[b];
      if (b < K - 1) sticky = sticky | i_x[b];
    end
    inc_mode = 1'b0;
    case (i_mode)
      MODE_FLOOR:     inc_mode = 1'b0;
      MODE_HALF_UP:   inc_mode = guard;
      MODE_HALF_EVEN: inc_mode = guard & (sticky | i_x[K]);
      MODE_TO_ZERO:   inc_mode = i_x[NB_XI-1] & (guard | sticky);
      default:        inc_mode = 1'b0;
    endcase
    y_d   = y_q;
    inc_d = inc_q;
    if (i_en) begin
      y_d   = i_x[NB_XI-1:K];
      inc_d = inc_mode;
    end
  end

  always_comb begin
    // One extra bit so +1 on the largest truncated value cannot wrap.
    y_round   = $signed({y_q[NB_Y-1], y_q}) + $signed({{NB_Y{1'b0}}, inc_q});
    y_round_i = int'(y_round);
    data_d    = data_q;
    sat_d     = sat_q;
    if (i_en) begin
      if (y_round_i > MAX_I) begin
        data_d = {1'b0, {(NB_XO-1){1'b1}}};
        sat_d  = 1'b1;
      end else if (y_round_i < MIN_I) begin
        data_d = {1'b1, {(NB_XO-1){1'b0}}};
        sat_d  = 1'b1;
      end else begin
        data_d = y_round[NB_XO-1:0];
        sat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_q    <= '0;
      inc_q  <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      y_q    <= y_d;
      inc_q  <= inc_d;
      data_q <= data_d;
      sat_q  <= sat_d;
    end
  end

  assign o_y   = data_q;
  assign o_sat = sat_q;

endmodule

// File: rtl/requant_pipe.sv
// rtl/requant_pipe.sv - handshaked two-stage multi-channel requantizer with saturation status
module requant_pipe
  import requant_pkg::*;
#(
  parameter int NB_XI  = 17,
  parameter int NBF_XI = 10,
  parameter int NB_XO  = 9,
  parameter int NBF_XO = 7,
  parameter int N_CH   = 2,
  parameter int NB_CNT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH*NB_XI-1:0] i_data,
  input  logic [1:0]            i_mode,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [N_CH*NB_XO-1:0] o_data,
  output logic [N_CH-1:0]       o_sat,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_clr,
  output logic [N_CH-1:0]       o_sat_sticky,
  output logic [NB_CNT-1:0]     o_sat_cnt
);

  logic              en, hs;
  logic              v1_q, v1_d;
  logic              valid_q, valid_d;
  logic [N_CH-1:0]   sticky_q, sticky_d;
  logic [NB_CNT-1:0] cnt_q, cnt_d;

  // Whole pipe moves as one; the output register is the only place a beat waits.
  assign en      = i_ready | ~valid_q;
  assign o_ready = en;
  assign hs      = valid_q & i_ready;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    requant_lane #(
      .NB_XI (NB_XI),
      .NBF_XI(NBF_XI),
      .NB_XO (NB_XO),
      .NBF_XO(NBF_XO)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_en   (en),
      .i_x    (i_data[c*NB_XI +: NB_XI]),
      .i_mode (i_mode),
      .o_y    (o_data[c*NB_XO +: NB_XO]),
      .o_sat  (o_sat[c])
    );
  end

  always_comb begin
    v1_d    = v1_q;
    valid_d = valid_q;
    if (en) begin
      v1_d    = i_valid;
      valid_d = v1_q;
    end
  end

  always_comb begin
    // Clear first, then the beat leaving this cycle is counted.
    sticky_d = i_clr ? '0 : sticky_q;
    cnt_d    = i_clr ? '0 : cnt_q;
    if (hs) begin
      sticky_d = sticky_d | o_sat;
      if ((|o_sat) && (cnt_d != '1)) cnt_d = cnt_d + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q     <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      v1_q     <= v1_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_sat_sticky = sticky_q;
  assign o_sat_cnt    = cnt_q;

endmodule

// File: tb/tb_requant_pipe.sv
// tb/tb_requant_pipe.sv - directed and randomized checks of requant_pipe (N_CH=3, NB_CNT=4)
module tb_requant_pipe;

  localparam int NB_XI  = 17;
  localparam int NBF_XI = 10;
  localparam int NB_XO  = 9;
  localparam int NBF_XO = 7;
  localparam int N_CH   = 3;
  localparam int NB_CNT = 4;
  localparam int K      = NBF_XI - NBF_XO;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic [N_CH*NB_XI-1:0] i_data = '0;
  logic [1:0]            i_mode = 2'd0;
  logic                  i_valid = 1'b0;
  logic                  o_ready;
  logic [N_CH*NB_XO-1:0] o_data;
  logic [N_CH-1:0]       o_sat;
  logic                  o_valid;
  logic                  i_ready = 1'b0;
  logic                  i_clr = 1'b0;
  logic [N_CH-1:0]       o_sat_sticky;
  logic [NB_CNT-1:0]     o_sat_cnt;

  int n_vec = 0;
  int n_err = 0;

  requant_pipe #(
    .NB_XI (NB_XI),
    .NBF_XI(NBF_XI),
    .NB_XO (NB_XO),
    .NBF_XO(NBF_XO),
    .N_CH  (N_CH),
    .NB_CNT(NB_CNT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_data      (i_data),
    .i_mode      (i_mode),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_sat       (o_sat),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .i_clr       (i_clr),
    .o_sat_sticky(o_sat_sticky),
    .o_sat_cnt   (o_sat_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Reference: floor quotient plus remainder, then clamp; returns {sat, data}.
  function automatic logic [NB_XO:0] golden(input int x, input int mode);
    int q, rem, half, r, maxv, minv;
    logic s;
    q    = x >>> K;
    rem  = x - (q * (1 << K));
    half = 1 << (K - 1);
    case (mode)
      0:       r = q;
      1:       r = q + ((rem >= half) ? 1 : 0);
      2:       r = q + (((rem > half) || ((rem == half) && ((q & 1) != 0))) ? 1 : 0);
      default: r = q + (((x < 0) && (rem != 0)) ? 1 : 0);
    endcase
    maxv = (1 << (NB_XO - 1)) - 1;
    minv = -(1 << (NB_XO - 1));
    s = 1'b0;
    if (r > maxv) begin r = maxv; s = 1'b1; end
    else if (r < minv) begin r = minv; s = 1'b1; end
    return {s, r[NB_XO-1:0]};
  endfunction

  task automatic set_all(input int x);
    for (int c = 0; c < N_CH; c++) i_data[c*NB_XI +: NB_XI] = x[NB_XI-1:0];
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_vec++;
    if ({o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b data=%h sat=%b sticky=%b cnt=%0d expected all zero",
               o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt);
    end
    n_vec++;
    if (o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_rounding();
    int xs [11];
    int ms [11];
    int es [11];
    int ev;
    logic [NB_XO-1:0] e9;
    xs = '{4, 4, 4, 4, 12, -4, -4, -4, -4, -5, -5};
    ms = '{0, 1, 2, 3, 2,  0,  1,  2,  3,  3,  1};
    es = '{0, 1, 0, 0, 2, -1,  0,  0,  0,  0, -1};
    i_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_all(xs[i]);
      i_mode  = ms[i][1:0];
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL round_latency%0d: o_valid got %b expected 0 one cycle after accept", i, o_valid);
      end
      @(posedge i_clk); #1;
      ev = es[i];
      e9 = ev[NB_XO-1:0];
      n_vec++;
      if ({o_valid, o_sat, o_data} !== {1'b1, {N_CH{1'b0}}, {N_CH{e9}}}) begin
        n_err++;
        $display("FAIL round_vec%0d x=%0d mode=%0d: got valid=%b sat=%b data=%h expected valid=1 sat=0 data=%h",
                 i, xs[i], ms[i], o_valid, o_sat, o_data, {N_CH{e9}});
      end
    end
    @(posedge i_clk); #1;
    n_vec++;
    if (o_sat_cnt !== 4'd0) begin
      n_err++;
      $display("FAIL round_cnt: got %0d expected 0", o_sat_cnt);
    end
  endtask

  task automatic test_saturation();
    int xs [5];
    int es [5];
    logic ss [5];
    int ev;
    logic [NB_XO-1:0] e9;
    xs = '{2040, 2044, 2048, -2048, -2056};
    es = '{255,  255,  255,  -256,  -256};
    ss = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b1};
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_all(xs[i]);
      i_mode  = (i == 1) ? 2'd2 : 2'd0;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      ev = es[i];
      e9 = ev[NB_XO-1:0];
      n_vec++;
      if ({o_valid, o_sat, o_data} !== {1'b1, {N_CH{ss[i]}}, {N_CH{e9}}}) begin
        n_err++;
        $display("FAIL sat_vec%0d x=%0d: got valid=%b sat=%b data=%h expected valid=1 sat=%b data=%h",
                 i, xs[i], o_valid, o_sat, o_data, {N_CH{ss[i]}}, {N_CH{e9}});
      end
    end
    @(posedge i_clk); #1;
    n_vec++;
    if ({o_sat_cnt, o_sat_sticky} !== {4'd3, 3'b111}) begin
      n_err++;
      $display("FAIL sat_status: got cnt=%0d sticky=%b expected cnt=3 sticky=111", o_sat_cnt, o_sat_sticky);
    end
  endtask

  task automatic test_backpressure();
    int in_idx, out_idx, exp_v;
    logic was_stall, acc;
    logic [N_CH*NB_XO-1:0] last_data, exp_d;
    in_idx = 0; out_idx = 0; was_stall = 1'b0; last_data = '0;
    i_mode = 2'd0;
    for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
      i_ready = !(cyc >= 4 && cyc <= 6);
      i_valid = (in_idx < 8);
      for (int c = 0; c < N_CH; c++) i_data[c*NB_XI +: NB_XI] = NB_XI'((in_idx + 1 + 10 * c) * 8);
      #1;
      if (was_stall) begin
        n_vec++;
        if (o_data !== last_data) begin
          n_err++;
          $display("FAIL bp_hold cyc%0d: got %h expected %h", cyc, o_data, last_data);
        end
      end
      if (o_valid && !i_ready) begin
        n_vec++;
        if (o_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_ready cyc%0d: got %b expected 0", cyc, o_ready);
        end
        was_stall = 1'b1;
        last_data = o_data;
      end else begin
        was_stall = 1'b0;
      end
      if (o_valid && i_ready) begin
        for (int c = 0; c < N_CH; c++) begin
          exp_v = out_idx + 1 + 10 * c;
          exp_d[c*NB_XO +: NB_XO] = exp_v[NB_XO-1:0];
        end
        n_vec++;
        if (o_data !== exp_d) begin
          n_err++;
          $display("FAIL bp_order beat%0d: got %h expected %h", out_idx, o_data, exp_d);
        end
        out_idx++;
      end
      acc = i_valid && o_ready;
      @(posedge i_clk); #1;
      if (acc) in_idx++;
    end
    i_valid = 1'b0;
    n_vec++;
    if (out_idx != 8 || in_idx != 8) begin
      n_err++;
      $display("FAIL bp_count: got in=%0d out=%0d expected 8 and 8", in_idx, out_idx);
    end
    repeat (2) @(posedge i_clk);
    #1;
    n_vec++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_extra: o_valid got %b expected 0 after drain", o_valid);
    end
  endtask

  task automatic test_clear();
    i_ready = 1'b1;
    i_mode  = 2'd0;
    i_data  = '0;
    i_data[NB_XI-1:0] = NB_XI'(2048);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    n_vec++;
    if ({o_sat_cnt, o_sat_sticky} !== {4'd1, 3'b001}) begin
      n_err++;
      $display("FAIL clr_with_beat: got cnt=%0d sticky=%b expected cnt=1 sticky=001", o_sat_cnt, o_sat_sticky);
    end
    i_clr = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    n_vec++;
    if ({o_sat_cnt, o_sat_sticky} !== {4'd0, 3'b000}) begin
      n_err++;
      $display("FAIL clr_alone: got cnt=%0d sticky=%b expected cnt=0 sticky=000", o_sat_cnt, o_sat_sticky);
    end
    set_all(-4000);
    i_valid = 1'b1;
    repeat (20) @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_sat_cnt, o_sat_sticky} !== {4'd15, 3'b111}) begin
      n_err++;
      $display("FAIL cnt_saturate: got cnt=%0d sticky=%b expected cnt=15 sticky=111", o_sat_cnt, o_sat_sticky);
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    i_mode  = 2'd0;
    set_all(800);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    set_all(808);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt} !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got valid=%b data=%h sat=%b sticky=%b cnt=%0d expected all zero",
               o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt);
    end
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      n_vec++;
      if (o_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stale cyc%0d: o_valid got %b expected 0", i, o_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [NB_XO*N_CH-1:0] qd[$];
    logic [N_CH-1:0]       qs[$];
    logic [NB_XO*N_CH-1:0] ed, pd;
    logic [N_CH-1:0]       es, ps, msticky;
    logic [NB_XO:0]        g;
    int xs [N_CH];
    int sent, got, mcnt, xv;
    sent = 0; got = 0; mcnt = 0; msticky = '0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_clr   = 1'b1;
    @(posedge i_clk); #1;
    i_clr = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 2000; cyc++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_valid = (sent < 2000) && ($urandom_range(0, 4) != 0);
      i_mode  = 2'($urandom_range(0, 3));
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 1) != 0) xv = int'($urandom_range(0, 4200)) - 2100;
        else begin
          xv = int'($urandom);
          xv = (xv <<< (32 - NB_XI)) >>> (32 - NB_XI);
        end
        xs[c] = xv;
        i_data[c*NB_XI +: NB_XI] = xv[NB_XI-1:0];
      end
      #1;
      if (i_valid && o_ready) begin
        for (int c = 0; c < N_CH; c++) begin
          g = golden(xs[c], int'(i_mode));
          ed[c*NB_XO +: NB_XO] = g[NB_XO-1:0];
          es[c] = g[NB_XO];
        end
        qd.push_back(ed);
        qs.push_back(es);
        sent++;
      end
      if (o_valid && i_ready) begin
        n_vec++;
        if (qd.size() == 0) begin
          n_err++;
          $display("FAIL rnd_unexpected cyc%0d: output beat with empty scoreboard data=%h", cyc, o_data);
        end else begin
          pd = qd.pop_front();
          ps = qs.pop_front();
          if ({o_sat, o_data} !== {ps, pd}) begin
            n_err++;
            $display("FAIL rnd_beat%0d: got sat=%b data=%h expected sat=%b data=%h", got, o_sat, o_data, ps, pd);
          end
          if (|ps) begin
            msticky = msticky | ps;
            if (mcnt < 15) mcnt++;
          end
        end
        got++;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    n_vec++;
    if (got != 2000) begin
      n_err++;
      $display("FAIL rnd_count: got %0d beats expected 2000", got);
    end
    n_vec++;
    if ({o_sat_cnt, o_sat_sticky} !== {4'(mcnt), msticky}) begin
      n_err++;
      $display("FAIL rnd_status: got cnt=%0d sticky=%b expected cnt=%0d sticky=%b",
               o_sat_cnt, o_sat_sticky, mcnt, msticky);
    end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
